// File: rtl/alu_exec.sv
// Multi-cycle ALU with registered write-back handshake (IDLE/EXEC/MUL/DONE).
// Define ALU_MUL_EN to build the 32-iteration shift-add multiplier for op 111.
module alu_exec (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [2:0]  dst,
  output logic        busy,
  output logic        done,
  output logic [1:0]  wb_cmd,
  output logic [2:0]  wb_sel,
  output logic [31:0] result,
  output logic [3:0]  flags
);

  localparam int unsigned DW  = 32;
  localparam int unsigned SW  = DW + 1;
  localparam int unsigned OPW = 3;
  localparam int unsigned RW  = 3;
  localparam int unsigned FW  = 4;
  localparam int unsigned SHW = 5;

  localparam logic [OPW-1:0] OP_ADD = 3'b000;
  localparam logic [OPW-1:0] OP_SUB = 3'b001;
  localparam logic [OPW-1:0] OP_AND = 3'b010;
  localparam logic [OPW-1:0] OP_OR  = 3'b011;
  localparam logic [OPW-1:0] OP_XOR = 3'b100;
  localparam logic [OPW-1:0] OP_SHL = 3'b101;
  localparam logic [OPW-1:0] OP_SHR = 3'b110;
`ifdef ALU_MUL_EN
  localparam logic [OPW-1:0] OP_MUL = 3'b111;
  localparam int unsigned    CW     = 5;
`endif

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
`ifdef ALU_MUL_EN
    S_MUL  = 2'd3,
`endif
    S_DONE = 2'd2
  } state_t;

  state_t          r_state;
  logic [OPW-1:0]  r_op;
  logic [DW-1:0]   r_a;
  logic [DW-1:0]   r_b;
  logic [RW-1:0]   r_dst;
  logic            r_busy;
  logic            r_done;
  logic [1:0]      r_wb_cmd;
  logic [RW-1:0]   r_wb_sel;
  logic [DW-1:0]   r_result;
  logic [FW-1:0]   r_flags;
`ifdef ALU_MUL_EN
  logic [DW-1:0]   r_acc;
  logic [CW-1:0]   r_cnt;
  logic [DW-1:0]   w_acc_nxt;
`endif

  logic            w_is_sub;
  logic [DW-1:0]   w_b_eff;
  logic [SW-1:0]   w_sum;
  logic [DW-1:0]   w_res;
  logic            w_c;
  logic            w_v;
  logic [FW-1:0]   w_flags;

  // Single-cycle datapath on the captured operands; flags are {Z,N,C,V}
  always_comb begin
    w_is_sub = (r_op == OP_SUB);
    w_b_eff  = w_is_sub ? ~r_b : r_b;
    w_sum    = {1'b0, r_a} + {1'b0, w_b_eff} + SW'(w_is_sub);
    w_res    = '0;
    w_c      = 1'b0;
    w_v      = 1'b0;
    case (r_op)
      OP_ADD, OP_SUB: begin
        w_res = w_sum[DW-1:0];
        w_c   = w_sum[DW];
        w_v   = (r_a[DW-1] == w_b_eff[DW-1]) && (w_sum[DW-1] != r_a[DW-1]);
      end
      OP_AND:  w_res = r_a & r_b;
      OP_OR:   w_res = r_a | r_b;
      OP_XOR:  w_res = r_a ^ r_b;
      OP_SHL:  w_res = r_a << r_b[SHW-1:0];
      OP_SHR:  w_res = r_a >> r_b[SHW-1:0];
      default: w_res = '0;
    endcase
    w_flags = {(w_res == '0), w_res[DW-1], w_c, w_v};
  end

`ifdef ALU_MUL_EN
  // One shift-add step: r_a carries the multiplicand, r_b the remaining multiplier bits
  assign w_acc_nxt = r_acc + (r_b[0] ? r_a : '0);
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state  <= S_IDLE;
      r_op     <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_dst    <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_wb_cmd <= 2'b00;
      r_wb_sel <= '0;
      r_result <= '0;
      r_flags  <= '0;
`ifdef ALU_MUL_EN
      r_acc    <= '0;
      r_cnt    <= '0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_op   <= op;
            r_a    <= a;
            r_b    <= b;
            r_dst  <= dst;
            r_busy <= 1'b1;
`ifdef ALU_MUL_EN
            r_acc   <= '0;
            r_cnt   <= '0;
            r_state <= (op == OP_MUL) ? S_MUL : S_EXEC;
`else
            r_state <= S_EXEC;
`endif
          end
        end
        S_EXEC: begin
          r_result <= w_res;
          r_flags  <= w_flags;
          r_wb_sel <= r_dst;
          r_done   <= 1'b1;
          r_wb_cmd <= 2'b11;
          r_state  <= S_DONE;
        end
`ifdef ALU_MUL_EN
        S_MUL: begin
          r_acc <= w_acc_nxt;
          r_a   <= r_a << 1;
          r_b   <= r_b >> 1;
          r_cnt <= r_cnt + CW'(1);
          if (r_cnt == CW'(DW - 1)) begin
            r_result <= w_acc_nxt;
            r_flags  <= {(w_acc_nxt == '0), w_acc_nxt[DW-1], 2'b00};
            r_wb_sel <= r_dst;
            r_done   <= 1'b1;
            r_wb_cmd <= 2'b11;
            r_state  <= S_DONE;
          end
        end
`endif
        S_DONE: begin
          r_done   <= 1'b0;
          r_wb_cmd <= 2'b00;
          r_busy   <= 1'b0;
          r_state  <= S_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign busy   = r_busy;
  assign done   = r_done;
  assign wb_cmd = r_wb_cmd;
  assign wb_sel = r_wb_sel;
  assign result = r_result;
  assign flags  = r_flags;

endmodule

// File: tb/tb_alu_exec.sv
// Randomized self-checking bench for alu_exec against an arithmetic reference model.
// Follows the DUT build: define ALU_MUL_EN for both to exercise the multiplier.
module tb_alu_exec;

  logic        clk;
  logic        rst;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic [2:0]  dst;
  logic        busy;
  logic        done;
  logic [1:0]  wb_cmd;
  logic [2:0]  wb_sel;
  logic [31:0] result;
  logic [3:0]  flags;

  int n_cmp;
  int n_err;

  alu_exec dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .op     (op),
    .a      (a),
    .b      (b),
    .dst    (dst),
    .busy   (busy),
    .done   (done),
    .wb_cmd (wb_cmd),
    .wb_sel (wb_sel),
    .result (result),
    .flags  (flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: plain wide arithmetic; flags {Z,N,C,V}
  function automatic void model(input logic [2:0] m_op, input logic [31:0] m_a, input logic [31:0] m_b,
                                output logic [31:0] r, output logic [3:0] f);
    logic [63:0]        u;
    longint             ss;
    logic signed [31:0] rs;
    logic               c;
    logic               v;
    c  = 1'b0;
    v  = 1'b0;
    u  = {32'd0, m_a} + {32'd0, m_b};
    ss = 0;
    case (m_op)
      3'd0: begin
        r  = u[31:0];
        c  = u[32];
        ss = longint'($signed(m_a)) + longint'($signed(m_b));
      end
      3'd1: begin
        r  = m_a - m_b;
        c  = (m_a >= m_b);
        ss = longint'($signed(m_a)) - longint'($signed(m_b));
      end
      3'd2: r = m_a & m_b;
      3'd3: r = m_a | m_b;
      3'd4: r = m_a ^ m_b;
      3'd5: r = m_a << m_b[4:0];
      3'd6: r = m_a >> m_b[4:0];
      default: begin
`ifdef ALU_MUL_EN
        u = {32'd0, m_a} * {32'd0, m_b};
        r = u[31:0];
`else
        r = 32'd0;
`endif
      end
    endcase
    rs = r;
    if (m_op == 3'd0 || m_op == 3'd1) v = (ss != longint'(rs));
    f = {(r == 32'd0), r[31], c, v};
  endfunction

  function automatic logic [31:0] pick();
    logic [31:0] tbl [5];
    tbl[0] = 32'h0000_0000;
    tbl[1] = 32'h0000_0001;
    tbl[2] = 32'h7FFF_FFFF;
    tbl[3] = 32'h8000_0000;
    tbl[4] = 32'hFFFF_FFFF;
    if ($urandom_range(0, 3) == 0) return tbl[$urandom_range(0, 4)];
    if ($urandom_range(0, 2) == 0) return 32'($urandom_range(0, 40));
    return $urandom;
  endfunction

  // Issue one op and verify latency, write-back pulse and hold afterwards.
  // glitch keeps start high (with a different ADD) into the busy phase.
  task automatic run_op(input logic [2:0] t_op, input logic [31:0] t_a, input logic [31:0] t_b,
                        input logic [2:0] t_dst, input bit glitch);
    logic [31:0] er;
    logic [3:0]  ef;
    int          lat;
    int          exp_lat;
    int          busy_low;
    int          extra;
    bit          got;
    model(t_op, t_a, t_b, er, ef);
    exp_lat = 1;
`ifdef ALU_MUL_EN
    if (t_op == 3'd7) exp_lat = 32;
`endif
    @(negedge clk);
    start = 1'b1; op = t_op; a = t_a; b = t_b; dst = t_dst;
    @(posedge clk); #1;
    op = glitch ? 3'd0 : 3'($urandom_range(0, 7));
    a = $urandom; b = $urandom; dst = ~t_dst;
    start = glitch;
    busy_low = busy ? 0 : 1;
    if (done) busy_low++;
    lat = 0;
    got = 1'b0;
    while (lat < 40 && !got) begin
      @(posedge clk); #1;
      start = 1'b0;
      lat++;
      if (done) got = 1'b1;
      else if (!busy) busy_low++;
    end
    check("latency", 32'(lat), 32'(exp_lat));
    check("result", result, er);
    check("flags", 32'(flags), 32'(ef));
    check("wb_cmd", 32'(wb_cmd), 32'd3);
    check("wb_sel", 32'(wb_sel), 32'(t_dst));
    check("busy_while_active", 32'(busy_low) | 32'({31'd0, ~busy}), 32'd0);
    @(posedge clk); #1;
    check("after_done_ctl", {27'd0, busy, done, wb_cmd, 1'b0}, 32'd0);
    check("result_hold", result, er);
    if (glitch) begin
      extra = 0;
      repeat (40) begin
        @(posedge clk); #1;
        if (done || wb_cmd != 2'b00 || busy) extra++;
      end
      check("ignored_start", 32'(extra), 32'd0);
    end
  endtask

  // Reset rst_at cycles after capture must abort without any write-back.
  task automatic abort_op(input logic [2:0] t_op, input int rst_at);
    int extra;
    @(negedge clk);
    start = 1'b1; op = t_op; a = 32'h0000_1234; b = 32'h0000_5678; dst = 3'd6;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (rst_at) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    check("abort_ctl", {26'd0, busy, done, wb_cmd, wb_sel}, 32'd0);
    check("abort_result", result, 32'd0);
    check("abort_flags", 32'(flags), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    extra = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done || wb_cmd == 2'b11 || busy) extra++;
    end
    check("abort_no_wb", 32'(extra), 32'd0);
  endtask

  initial begin
    logic [2:0] r_op_v;
    n_cmp = 0;
    n_err = 0;
    rst = 1'b0; start = 1'b0; op = 3'd0; a = '0; b = '0; dst = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_ctl", {26'd0, busy, done, wb_cmd, wb_sel}, 32'd0);
    check("reset_result", result, 32'd0);
    check("reset_flags", 32'(flags), 32'd0);
    @(negedge clk);
    rst = 1'b1;

    run_op(3'd0, 32'hFFFF_FFFF, 32'h0000_0001, 3'd5, 1'b0);
    run_op(3'd1, 32'h8000_0000, 32'h0000_0001, 3'd2, 1'b0);
    run_op(3'd1, 32'h0000_0001, 32'h0000_0002, 3'd3, 1'b0);
    run_op(3'd5, 32'h0000_0001, 32'h0000_0020, 3'd1, 1'b0);
    run_op(3'd6, 32'h8000_0000, 32'd31,        3'd7, 1'b0);
    run_op(3'd7, 32'd7,         32'd6,         3'd4, 1'b0);
    run_op(3'd7, 32'h0001_0000, 32'h0001_0000, 3'd0, 1'b0);
    run_op(3'd7, 32'h0000_1234, 32'h0000_0077, 3'd6, 1'b1);
    run_op(3'd0, 32'h7FFF_FFFF, 32'h0000_0001, 3'd1, 1'b1);

    for (int i = 0; i < 40; i++) begin
      r_op_v = 3'($urandom_range(0, 7));
      run_op(r_op_v, pick(), pick(), 3'($urandom_range(0, 7)), 1'b0);
    end

    run_op(3'd4, 32'hDEAD_BEEF, 32'h0F0F_0F0F, 3'd5, 1'b0);
`ifdef ALU_MUL_EN
    abort_op(3'd7, 9);
`else
    abort_op(3'd0, 0);
`endif

    @(negedge clk);
    rst = 1'b0; start = 1'b1; op = 3'd0;
    @(posedge clk); #1;
    @(negedge clk);
    rst = 1'b1; start = 1'b0;
    @(posedge clk); #1;
    check("rst_over_start", {29'd0, busy, done, 1'b0}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/alu_exec.md
ALU_EXEC -- requirements
Module: alu_exec

Interface
REQ-001 SHALL have port clk, input, 1 bit: clock; all state updates on its rising edge.
REQ-002 SHALL have port rst, input, 1 bit: reset, synchronous, active-low.
REQ-003 SHALL have port start, input, 1 bit: request a new operation; sampled only in IDLE.
REQ-004 SHALL have port op, input, 3 bits: opcode, 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SHL, 110 SHR (logical), 111 MUL.
REQ-005 SHALL have ports a and b, input, 32 bits each: operands taken from the register-file A/B read ports.
REQ-006 SHALL have port dst, input, 3 bits: destination register index for the write-back.
REQ-007 SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-008 SHALL have port done, output, 1 bit: one-cycle completion pulse.
REQ-009 SHALL have port wb_cmd, output, 2 bits: 2'b11 while done is high, 2'b00 otherwise; drives the register-file write command.
REQ-010 SHALL have port wb_sel, output, 3 bits: captured dst; drives the register-file write select.
REQ-011 SHALL have port result, output, 32 bits: the write-back data.
REQ-012 SHALL have port flags, output, 4 bits: {Z,N,C,V}.

Function
REQ-013 SHALL implement FSM states IDLE, EXEC, MUL and DONE.
REQ-014 In IDLE, start=1 at edge N SHALL capture op, a, b and dst, then move to MUL if op=111, else to EXEC.
REQ-015 EXEC SHALL compute and register result and flags at edge N+1, then move to DONE.
REQ-016 DONE SHALL last exactly one cycle with done=1 and wb_cmd=11, then return to IDLE; a single-cycle op therefore reports done in the cycle after edge N+1.
REQ-017 MUL SHALL be a shift-add multiply of 32 iterations producing the low 32 bits of a*b; DONE SHALL follow edge N+32, so done is high in the cycle after edge N+32.
REQ-018 start SHALL be ignored in EXEC, MUL and DONE; no queuing.
REQ-019 ADD/SUB SHALL use a 33-bit sum; SUB is a + ~b + 1.
REQ-020 C SHALL be the carry-out (SUB: 1 when a >= b unsigned); V SHALL be signed overflow.
REQ-021 SHL/SHR SHALL shift a by b[4:0]; b[4:0]=0 SHALL return a unchanged.
REQ-022 Z SHALL be result==0 and N SHALL be result[31]; C and V SHALL be 0 for logic, shift and MUL ops.
REQ-023 result, flags and wb_sel SHALL hold their values from the end of DONE until the next completion.
REQ-024 Outputs are registered; no combinational path SHALL exist from inputs to outputs.

Reset
REQ-025 rst=0 at any edge SHALL force state IDLE, busy=0, done=0, wb_cmd=00, wb_sel=0, result=0, flags=0 and clear the multiplier iteration counter.
REQ-026 Reset during EXEC, MUL or DONE SHALL abort the operation with no write-back pulse.
REQ-027 rst has priority over start on the same edge.

Configuration
REQ-028 Macro ALU_MUL_EN defined: op 111 SHALL use the MUL state as per REQ-017.
REQ-029 ALU_MUL_EN undefined: SHALL omit MUL state and multiplier logic; op 111 SHALL take the EXEC path with result=0, flags Z=1 and N=C=V=0, and two-cycle latency.

Verification
REQ-030 ADD a=0xFFFFFFFF b=0x00000001 dst=5 -> cycle after edge N+1: result=0, flags Z=1 N=0 C=1 V=0, done=1, wb_cmd=11, wb_sel=5.
REQ-031 SUB a=0x80000000 b=0x00000001 -> result=0x7FFFFFFF, Z=0 N=0 C=1 V=1; SUB a=1 b=2 -> result=0xFFFFFFFF, N=1 C=0.
REQ-032 With ALU_MUL_EN: MUL 7*6 -> result=42, done in cycle after edge N+32; MUL 0x00010000*0x00010000 -> result=0, Z=1; busy high throughout.
REQ-033 start pulsed during MUL with op=ADD -> ignored: one done pulse only, with the MUL result.
REQ-034 rst=0 at iteration 10 of MUL -> next cycle busy=0, result=0, flags=0; no done or wb_cmd=11 until a new start.
REQ-035 SHL a=0x00000001 b=0x00000020 -> result=0x00000001; SHR a=0x80000000 b=31 -> result=0x00000001, N=0.
